// File: rtl/seven_segment_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : seven_segment_monitor
//  Purpose  : Passive decoder for a time-multiplexed, active-low seven-segment
//             bus. Rebuilds per-digit hex values and digit points, flags
//             illegal bus states and marks completed scan frames.
//  Revision : 1.0 - initial release
// ============================================================================
module seven_segment_monitor #(
   parameter int NUM_SEGMENTS  = 8,
   parameter int SYNC_STAGES   = 2,
   parameter int STABLE_CYCLES = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [0:NUM_SEGMENTS-1]      anode,
   input  logic [7:0]                   cathode,
   output logic [NUM_SEGMENTS-1:0][3:0] encoded,
   output logic [NUM_SEGMENTS-1:0]      digit_point,
   output logic [NUM_SEGMENTS-1:0]      digit_valid,
   output logic                         frame_done,
   output logic                         pattern_err,
   output logic                         anode_err
);

   localparam int c_BUS_W = NUM_SEGMENTS + 8;
   localparam int c_RUN_W = $clog2(STABLE_CYCLES + 1);
   localparam int c_IDX_W = $clog2(NUM_SEGMENTS);
   localparam logic [c_RUN_W-1:0] c_RUN_SAT  = c_RUN_W'(STABLE_CYCLES);
   localparam logic [c_RUN_W-1:0] c_RUN_FIRE = c_RUN_W'(STABLE_CYCLES - 1);

   // Bus word: bit 8+i is anode[i], bits 7:0 are the cathode lines.
   logic [c_BUS_W-1:0] w_bus;
   logic [c_BUS_W-1:0] r_sync [SYNC_STAGES];
   logic [c_BUS_W-1:0] w_sample;
   logic [c_BUS_W-1:0] r_prev;
   logic [c_RUN_W-1:0] r_run;
   logic [c_RUN_W-1:0] w_run_cur;
   logic               w_fire;
   logic               r_cap_valid;
   logic [c_BUS_W-1:0] r_cap_bus;

   logic [NUM_SEGMENTS-1:0] w_zeros;
   logic                    w_single;
   logic                    w_multi;
   logic [c_IDX_W-1:0]      w_idx;
   logic [6:0]              w_pattern;
   logic [3:0]              w_hex_val;
   logic                    w_hex_ok;
   logic [NUM_SEGMENTS-1:0] r_seen;
   logic [NUM_SEGMENTS-1:0] w_seen_next;

   assign w_bus[7:0] = cathode;

   generate
      for (genvar gi = 0; gi < NUM_SEGMENTS; gi++) begin : g_anode_map
         assign w_bus[8+gi] = anode[gi];
      end
   endgenerate

   // Synchronizer chain; reset loads the idle (all ones) bus state.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= '1;
      end else begin
         r_sync[0] <= w_bus;
         for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
      end
   end

   assign w_sample = r_sync[SYNC_STAGES-1];

   // Cycles the sample has already been held before this one; a change restarts at zero.
   assign w_run_cur = (w_sample != r_prev) ? '0 : r_run;
   // Fires on the STABLE_CYCLES-th identical cycle; saturation makes it once per run.
   assign w_fire    = (w_run_cur == c_RUN_FIRE);

   // Stability counter plus a one-deep capture register so all decode outputs are registered.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_prev      <= '1;
         r_run       <= '0;
         r_cap_valid <= 1'b0;
         r_cap_bus   <= '1;
      end else begin
         r_prev      <= w_sample;
         r_run       <= (w_run_cur == c_RUN_SAT) ? w_run_cur : w_run_cur + c_RUN_W'(1);
         r_cap_valid <= w_fire;
         r_cap_bus   <= w_sample;
      end
   end

   assign w_zeros  = ~r_cap_bus[c_BUS_W-1:8];
   assign w_single = (w_zeros != '0) && ((w_zeros & (w_zeros - NUM_SEGMENTS'(1))) == '0);
   assign w_multi  = (w_zeros != '0) && !w_single;
   assign w_pattern = ~r_cap_bus[6:0];
   assign w_seen_next = r_seen | (NUM_SEGMENTS'(1) << w_idx);

   // Index of the selected digit (meaningful only when exactly one anode is low).
   always_comb begin
      w_idx = '0;
      for (int i = 0; i < NUM_SEGMENTS; i++) begin
         if (w_zeros[i]) w_idx = c_IDX_W'(i);
      end
   end

   // Segment pattern (g..a, active high) to hex digit.
   always_comb begin
      w_hex_val = 4'h0;
      w_hex_ok  = 1'b1;
      case (w_pattern)
         7'h3F: w_hex_val = 4'h0;
         7'h06: w_hex_val = 4'h1;
         7'h5B: w_hex_val = 4'h2;
         7'h4F: w_hex_val = 4'h3;
         7'h66: w_hex_val = 4'h4;
         7'h6D: w_hex_val = 4'h5;
         7'h7D: w_hex_val = 4'h6;
         7'h07: w_hex_val = 4'h7;
         7'h7F: w_hex_val = 4'h8;
         7'h6F: w_hex_val = 4'h9;
         7'h77: w_hex_val = 4'hA;
         7'h7C: w_hex_val = 4'hB;
         7'h39: w_hex_val = 4'hC;
         7'h5E: w_hex_val = 4'hD;
         7'h79: w_hex_val = 4'hE;
         7'h71: w_hex_val = 4'hF;
         default: w_hex_ok = 1'b0;
      endcase
   end

   // Apply a capture: update the digit, raise error pulses and track the frame mask.
   always_ff @(posedge clk) begin
      if (reset) begin
         encoded     <= '0;
         digit_point <= '0;
         digit_valid <= '0;
         frame_done  <= 1'b0;
         pattern_err <= 1'b0;
         anode_err   <= 1'b0;
         r_seen      <= '0;
      end else begin
         frame_done  <= 1'b0;
         pattern_err <= 1'b0;
         anode_err   <= 1'b0;
         if (r_cap_valid) begin
            if (w_multi) begin
               anode_err <= 1'b1;
            end else if (w_single) begin
               if (w_hex_ok) begin
                  encoded[w_idx]     <= w_hex_val;
                  digit_point[w_idx] <= ~r_cap_bus[7];
                  digit_valid[w_idx] <= 1'b1;
               end else begin
                  digit_valid[w_idx] <= 1'b0;
                  pattern_err        <= 1'b1;
               end
               if (&w_seen_next) begin
                  frame_done <= 1'b1;
                  r_seen     <= '0;
               end else begin
                  r_seen <= w_seen_next;
               end
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_seven_segment_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seven_segment_monitor
//  Purpose  : Self-checking bench for seven_segment_monitor: window-based
//             reference model over the sampled bus history plus directed
//             literal checks and a driver-style loopback scan.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seven_segment_monitor;

   localparam int N    = 8;
   localparam int SS   = 2;
   localparam int ST   = 4;
   localparam int MAXC = 20000;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic [0:N-1] anode = '1;
   logic [7:0] cathode = 8'hFF;
   logic [N-1:0][3:0] encoded;
   logic [N-1:0] digit_point;
   logic [N-1:0] digit_valid;
   logic frame_done, pattern_err, anode_err;

   seven_segment_monitor #(
      .NUM_SEGMENTS(N), .SYNC_STAGES(SS), .STABLE_CYCLES(ST)
   ) dut (
      .clk(clk), .reset(reset), .anode(anode), .cathode(cathode),
      .encoded(encoded), .digit_point(digit_point), .digit_valid(digit_valid),
      .frame_done(frame_done), .pattern_err(pattern_err), .anode_err(anode_err)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   int cyc = 16;
   int n_fd = 0, n_pe = 0, n_ae = 0;
   bit chk_en = 1'b0;

   function automatic logic [6:0] seg_of(input int v);
      case (v)
         0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
         4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
         8: return 7'h7F;  9: return 7'h6F; 10: return 7'h77; 11: return 7'h7C;
        12: return 7'h39; 13: return 7'h5E; 14: return 7'h79; default: return 7'h71;
      endcase
   endfunction

   function automatic logic [7:0] cat_of(input int v, input logic dp);
      return ~{dp, seg_of(v)};
   endfunction

   function automatic logic [0:N-1] sel(input int i);
      logic [0:N-1] a;
      a = '1;
      a[i] = 1'b0;
      return a;
   endfunction

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (edge %0d)", name, got, exp, cyc);
      end
   endtask

   // ---------------- reference model ----------------
   // samp[e] is the bus value that entered the synchronizer at edge e. A capture
   // lands at edge e = k + SS + ST when samp[k..k+ST-1] are identical and k starts
   // a run (value differs from samp[k-1], or a reset forced a run boundary).
   logic [N+7:0] samp [MAXC];
   bit           brk  [MAXC];
   int           last_rst = -1000;
   logic [N-1:0][3:0] m_enc;
   logic [N-1:0] m_dp, m_val, m_seen;
   logic m_fd, m_pe, m_ae;
   logic [N+7:0] m_cur, m_cap;
   int m_k, m_nz, m_idx, m_v;
   bit m_ok;

   initial begin
      for (int j = 0; j < MAXC; j++) begin
         samp[j] = '1;
         brk[j]  = 1'b0;
      end
      m_enc = '0; m_dp = '0; m_val = '0; m_seen = '0;
      m_fd = 1'b0; m_pe = 1'b0; m_ae = 1'b0;
   end

   always @(posedge clk) begin
      cyc++;
      if (cyc >= MAXC - 1) begin
         $display("FAIL cycle_budget: got %0d expected below %0d", cyc, MAXC - 1);
         $fatal(1, "cycle budget exhausted");
      end
      for (int i = 0; i < N; i++) m_cur[8+i] = anode[i];
      m_cur[7:0] = cathode;
      samp[cyc] = m_cur;
      brk[cyc]  = 1'b0;
      m_fd = 1'b0; m_pe = 1'b0; m_ae = 1'b0;
      if (reset) begin
         for (int j = cyc - SS + 1; j <= cyc; j++) begin
            samp[j] = '1;
            brk[j]  = 1'b0;
         end
         brk[cyc-SS+1] = 1'b1;
         last_rst = cyc;
         m_enc = '0; m_dp = '0; m_val = '0; m_seen = '0;
      end else if (cyc >= last_rst + ST + 1) begin
         m_k  = cyc - SS - ST;
         m_ok = brk[m_k] || (samp[m_k-1] != samp[m_k]);
         for (int j = 1; j < ST; j++) if (samp[m_k+j] != samp[m_k]) m_ok = 1'b0;
         if (m_ok) begin
            m_cap = samp[m_k];
            m_nz = 0;
            m_idx = 0;
            for (int i = 0; i < N; i++) if (!m_cap[8+i]) begin m_nz++; m_idx = i; end
            if (m_nz > 1) begin
               m_ae = 1'b1;
            end else if (m_nz == 1) begin
               m_v = -1;
               for (int v = 0; v < 16; v++) if (seg_of(v) == ~m_cap[6:0]) m_v = v;
               if (m_v >= 0) begin
                  m_enc[m_idx] = m_v[3:0];
                  m_dp[m_idx]  = ~m_cap[7];
                  m_val[m_idx] = 1'b1;
               end else begin
                  m_val[m_idx] = 1'b0;
                  m_pe = 1'b1;
               end
               m_seen[m_idx] = 1'b1;
               if (m_seen == '1) begin
                  m_fd = 1'b1;
                  m_seen = '0;
               end
            end
         end
      end
   end

   // ---------------- per-cycle compare + pulse counters ----------------
   always @(negedge clk) begin
      if (chk_en) begin
         check("encoded", encoded, m_enc);
         check("digit_point", digit_point, m_dp);
         check("digit_valid", digit_valid, m_val);
         check("frame_done", frame_done, m_fd);
         check("pattern_err", pattern_err, m_pe);
         check("anode_err", anode_err, m_ae);
      end
      if (frame_done === 1'b1) n_fd++;
      if (pattern_err === 1'b1) n_pe++;
      if (anode_err === 1'b1) n_ae++;
   end

   // ---------------- stimulus ----------------
   task automatic hold(input logic [0:N-1] a, input logic [7:0] c, input int n);
      anode = a;
      cathode = c;
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      anode = '1;
      cathode = 8'hFF;
      @(negedge clk);
      reset = 1'b0;
   endtask

   logic [31:0] frame_word;
   logic [7:0]  frame_dp;
   logic [0:N-1] r_a;
   logic [7:0] r_c;
   int p, snap;

   initial begin
      frame_word = 32'h0123_4567;
      frame_dp   = 8'h81;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      chk_en = 1'b1;

      // Idle bus after reset.
      hold('1, 8'hFF, 50);
      check("idle_encoded", encoded, 64'h0);
      check("idle_dp", digit_point, 64'h0);
      check("idle_valid", digit_valid, 64'h0);
      check("idle_pulses", n_fd + n_pe + n_ae, 64'd0);

      // Digit 2 shows "2", then "2." with the point lit.
      hold(sel(2), 8'hA4, 10);
      check("d2_enc", encoded[2], 64'h2);
      check("d2_dp", digit_point[2], 64'h0);
      check("d2_valid", digit_valid[2], 64'h1);
      check("model_d2_enc", m_enc[2], 64'h2);
      hold(sel(2), 8'h24, 10);
      check("d2_dp_lit", digit_point[2], 64'h1);

      // Short glitch is rejected; a run of exactly ST cycles is accepted.
      snap = n_fd + n_pe + n_ae;
      hold(sel(2), 8'hF9, 3);
      hold(sel(2), 8'h24, 10);
      check("glitch_enc", encoded[2], 64'h2);
      check("glitch_dp", digit_point[2], 64'h1);
      check("glitch_pulses", n_fd + n_pe + n_ae - snap, 64'd0);
      hold(sel(2), 8'hF9, 4);
      hold('1, 8'hFF, 10);
      check("run4_enc", encoded[2], 64'h1);
      check("model_run4_enc", m_enc[2], 64'h1);

      // Illegal pattern on digit 5.
      snap = n_pe;
      hold(sel(5), 8'hFF, 12);
      check("d5_pattern_pulses", n_pe - snap, 64'd1);
      check("d5_valid", digit_valid[5], 64'h0);
      check("d5_enc", encoded[5], 64'h0);

      // Two anodes low together.
      snap = n_ae;
      r_a = '1; r_a[1] = 1'b0; r_a[3] = 1'b0;
      hold(r_a, 8'hA4, 12);
      check("anode_err_pulses", n_ae - snap, 64'd1);
      check("anode_err_enc", encoded, 64'h0000_0100);
      check("anode_err_valid", digit_valid, 64'h04);
      check("anode_err_dp", digit_point, 64'h00);
      hold('1, 8'hFF, 10);

      // Randomized bus activity with occasional resets.
      for (int r = 0; r < 300; r++) begin
         p = $urandom_range(0, 99);
         if (p < 70) r_a = sel($urandom_range(0, N-1));
         else if (p < 85) r_a = '1;
         else r_a = $urandom;
         p = $urandom_range(0, 99);
         if (p < 70) r_c = cat_of($urandom_range(0, 15), 1'($urandom_range(0, 1)));
         else r_c = 8'($urandom);
         hold(r_a, r_c, $urandom_range(1, 7));
         if (r % 97 == 50) pulse_reset();
      end

      // Loopback: driver-style scan, 20 cycles per digit.
      pulse_reset();
      hold('1, 8'hFF, 10);
      snap = n_fd;
      for (int f = 0; f < 3; f++)
         for (int i = 0; i < N; i++)
            hold(sel(i), cat_of(int'(frame_word[4*i +: 4]), frame_dp[i]), 20);
      check("loop_enc", encoded, 64'h0123_4567);
      check("loop_dp", digit_point, 64'h81);
      check("loop_valid", digit_valid, 64'hFF);
      check("loop_frames", n_fd - snap, 64'd3);

      // Reset mid-frame discards the partial frame.
      snap = n_fd;
      for (int i = 0; i < 4; i++)
         hold(sel(i), cat_of(int'(frame_word[4*i +: 4]), frame_dp[i]), 20);
      pulse_reset();
      check("midrst_enc", encoded, 64'h0);
      check("midrst_dp", digit_point, 64'h0);
      check("midrst_valid", digit_valid, 64'h0);
      for (int j = 4; j < 11; j++)
         hold(sel(j % N), cat_of(int'(frame_word[4*(j%N) +: 4]), frame_dp[j%N]), 20);
      check("midrst_no_frame", n_fd - snap, 64'd0);
      hold(sel(3), cat_of(int'(frame_word[12 +: 4]), frame_dp[3]), 20);
      check("midrst_frame", n_fd - snap, 64'd1);
      hold('1, 8'hFF, 10);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/seven_segment_monitor.md
# seven_segment_monitor

Passive decoder for the time-multiplexed seven-segment bus: it samples the active-low `anode`/`cathode` lines produced by the display driver and rebuilds the per-digit hex values and digit points. It also flags illegal bus states and marks completed scan frames. It sits beside the display driver for on-chip loopback self-check, or at the FPGA pins of a board-level bench.

## Interface
- `NUM_SEGMENTS`, 8, number of multiplexed digits (≥2).
- `SYNC_STAGES`, 2, synchronizer flops on every bus bit (≥2).
- `STABLE_CYCLES`, 4, consecutive identical synchronized samples required to accept a bus state (≥1).

Ports (clock and reset first):
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `anode`  in  [0:NUM_SEGMENTS-1]  digit selects, active low; `anode[i]`=0 selects digit i.
- `cathode`  in  [7:0]  active-low segments: bit0..6 = a..g, bit7 = dp.
- `encoded`  out  [NUM_SEGMENTS-1:0][3:0]  last decoded hex value per digit.
- `digit_point`  out  [NUM_SEGMENTS-1:0]  last dp per digit, 1 = lit.
- `digit_valid`  out  [NUM_SEGMENTS-1:0]  1 = last capture of that digit decoded legally.
- `frame_done`  out  1  one-cycle pulse when every digit has been captured since the last pulse.
- `pattern_err`  out  1  one-cycle pulse: selected digit shows a non-hex pattern.
- `anode_err`  out  1  one-cycle pulse: more than one anode low.

## Operation
- Synchronizer: `{anode,cathode}` passes through `SYNC_STAGES` flops; the last stage is the sample `S`.
- Stability: run counter counts consecutive cycles with `S` unchanged and resets on any change. It saturates after firing.
- One capture event fires on the cycle `S` has been identical for `STABLE_CYCLES` cycles, once per run. A changed `S` starts a new run.
- On capture, classify the anode field:
  - All ones (blank): no update, no error.
  - Exactly one zero at index i: decode digit i.
  - Two or more zeros: pulse `anode_err`; no output, mask or frame change.
- Decode of digit i: active-high pattern P = `~cathode[6:0]` (g..a) is matched against 0..F = 3F,06,5B,4F,66,6D,7D,07,7F,6F,77,7C,39,5E,79,71.
  - Match: `encoded[i]` ← value, `digit_point[i]` ← `~cathode[7]`, `digit_valid[i]` ← 1.
  - No match: `digit_valid[i]` ← 0, `pattern_err` pulse, `encoded[i]` and `digit_point[i]` hold.
- Frame mask: `seen[i]` is set on any single-anode capture of digit i, legal or not.
  - When a capture makes `seen` all ones: `frame_done` pulses and `seen` clears to 0 in the same cycle.
  - Recapturing an already-seen digit is harmless.
- Reset mid-operation: all state returns to reset values on the next edge. A partial frame is discarded and the run counter restarts.

## Timing
- Reset values:
  - Synchronizer flops all ones (idle bus).
  - Run counter 0, `seen` 0.
  - `encoded` 0, `digit_point` 0, `digit_valid` 0.
  - `frame_done`, `pattern_err`, `anode_err` 0.
- Latency: a new bus value first sampled on edge k updates `encoded`, `digit_point` and `digit_valid` and raises pulses at edge k + `SYNC_STAGES` + `STABLE_CYCLES`. All outputs are registered.
- Rejection: a bus value held for fewer than `STABLE_CYCLES` synchronized cycles produces no capture.
- Holding a value indefinitely yields exactly one capture.
- Error pulses and `frame_done` last exactly 1 cycle.
- `frame_done` and `pattern_err` may assert in the same cycle (the last digit of a frame is illegal).
- No backpressure, no handshake. Throughput is one capture per run, minimum run length `STABLE_CYCLES` cycles.

## Test plan
- Reset, then idle bus (all ones) for 50 cycles -> all outputs 0, no pulses.
- `anode[2]`=0, others 1, `cathode`=8'hA4, held 10 cycles -> after 7 cycles: `encoded[2]`=4'h2, `digit_point[2]`=0, `digit_valid[2]`=1.
  - Then `cathode`=8'h24 -> `digit_point[2]`=1.
- Glitch: same digit-2 state, then `cathode`=8'hF9 for 3 cycles, then back -> no change, no pulses.
  - `cathode`=8'hF9 for 4 cycles -> `encoded[2]`=4'h1.
- Digit 5 selected, `cathode`=8'hFF held -> `pattern_err` one pulse, `digit_valid[5]`=0, `encoded[5]` unchanged.
  - `anode[1]` and `anode[3]` low together -> `anode_err` one pulse, no output change.
- Loopback with the display driver (8 digits, 10 ns clock, refresh interval shortened to 20 cycles), `encoded`=32'h0123_4567, `digit_point`=8'h81:
  - Each digit i reproduces the driver input value, and `digit_point` tracks 8'h81.
  - All `digit_valid`=1.
  - `frame_done` pulses once per 8 digits scanned.
  - Reset asserted mid-frame: outputs zero, first `frame_done` only after 8 fresh captures.
